// File: rtl/ncc_match_engine.sv
// Template-vs-window unsigned cross-correlation engine with best-match tracking.
// The template loads as a lane-wide stream; candidate windows arrive one row per beat.
module ncc_match_engine #(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned TPL_DIM = 16,
   parameter int unsigned LANES   = 4,
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned IDX_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     desc_valid,
   output logic                     desc_ready,
   input  logic [LANES*PIX_W-1:0]   desc_data,
   input  logic                     desc_reload,
   input  logic                     win_valid,
   output logic                     win_ready,
   input  logic [TPL_DIM*PIX_W-1:0] win_data,
   input  logic                     frame_clear,
   output logic                     score_valid,
   output logic [ACC_W-1:0]         score,
   output logic                     best_valid,
   output logic [ACC_W-1:0]         best_score,
   output logic [IDX_W-1:0]         best_idx
);

   localparam int unsigned Beats      = TPL_DIM * TPL_DIM / LANES;
   localparam int unsigned BeatsPerRow = TPL_DIM / LANES;
   localparam int unsigned BW         = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned RW         = (TPL_DIM > 1) ? $clog2(TPL_DIM) : 1;
   localparam int unsigned CW         = (BeatsPerRow > 1) ? $clog2(BeatsPerRow) : 1;
   localparam int unsigned RowW       = TPL_DIM * PIX_W;
   localparam int unsigned BeatW      = LANES * PIX_W;
   localparam logic [BW-1:0] BLast    = BW'(Beats - 1);
   localparam logic [RW-1:0] RLast    = RW'(TPL_DIM - 1);

   if (ACC_W < 2 * PIX_W + $clog2(TPL_DIM * TPL_DIM)) begin : g_acc_w_check
      $error("ACC_W too narrow to hold a full-scale window score");
   end
   if (TPL_DIM % LANES != 0) begin : g_lanes_check
      $error("TPL_DIM must be a multiple of LANES");
   end

   typedef enum logic [1:0] {StDesc, StWin, StCommit} state_e;

   state_e            state_q;
   logic [BW-1:0]     b_q;
   logic [RW-1:0]     r_q;
   logic [ACC_W-1:0]  acc_q;
   logic [IDX_W-1:0]  win_idx_q;
   logic              reload_pend_q;

   // Template rows stored packed, column 0 in the MSBs to match win_data.
   logic [RowW-1:0]   tpl_q [TPL_DIM];
   logic [RW-1:0]     wr_row;
   logic [CW-1:0]     wr_col;

   assign wr_row = RW'(32'(b_q) / BeatsPerRow);
   assign wr_col = CW'(32'(b_q) % BeatsPerRow);

   always_ff @(posedge clk) begin
      if (state_q == StDesc && desc_valid) begin
         tpl_q[wr_row][(BeatsPerRow - 1 - 32'(wr_col)) * BeatW +: BeatW] <= desc_data;
      end
   end

   logic [ACC_W-1:0]   row_sum;
   logic [ACC_W-1:0]   acc_next;
   logic [RowW-1:0]    tpl_row;
   logic [2*PIX_W-1:0] prod;

   always_comb begin
      row_sum = '0;
      prod    = '0;
      tpl_row = tpl_q[r_q];
      for (int c = 0; c < TPL_DIM; c++) begin
         prod = {{PIX_W{1'b0}}, win_data[(TPL_DIM - 1 - c) * PIX_W +: PIX_W]} *
                {{PIX_W{1'b0}}, tpl_row[(TPL_DIM - 1 - c) * PIX_W +: PIX_W]};
         row_sum = row_sum + ACC_W'(prod);
      end
      acc_next = (r_q == '0) ? row_sum : acc_q + row_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StDesc;
         b_q           <= '0;
         r_q           <= '0;
         acc_q         <= '0;
         win_idx_q     <= '0;
         reload_pend_q <= 1'b0;
         desc_ready    <= 1'b1;
         win_ready     <= 1'b0;
         score_valid   <= 1'b0;
         score         <= '0;
         best_valid    <= 1'b0;
         best_score    <= '0;
         best_idx      <= '0;
      end else begin
         score_valid <= 1'b0;
         unique case (state_q)
            StDesc: begin
               if (desc_valid) begin
                  if (b_q == BLast) begin
                     b_q        <= '0;
                     state_q    <= StWin;
                     desc_ready <= 1'b0;
                     win_ready  <= 1'b1;
                  end else begin
                     b_q <= b_q + BW'(1);
                  end
               end
            end
            StWin: begin
               // A reload between windows is taken at once; mid-window it waits for commit.
               if (desc_reload && r_q == '0) begin
                  state_q    <= StDesc;
                  b_q        <= '0;
                  desc_ready <= 1'b1;
                  win_ready  <= 1'b0;
               end else begin
                  if (desc_reload) begin
                     reload_pend_q <= 1'b1;
                  end
                  if (win_valid) begin
                     acc_q <= acc_next;
                     if (r_q == RLast) begin
                        r_q         <= '0;
                        state_q     <= StCommit;
                        win_ready   <= 1'b0;
                        score_valid <= 1'b1;
                        score       <= acc_next;
                     end else begin
                        r_q <= r_q + RW'(1);
                     end
                  end
               end
            end
            StCommit: begin
               if (!best_valid || acc_q > best_score) begin
                  best_valid <= 1'b1;
                  best_score <= acc_q;
                  best_idx   <= win_idx_q;
               end
               win_idx_q     <= win_idx_q + IDX_W'(1);
               reload_pend_q <= 1'b0;
               if (reload_pend_q || desc_reload) begin
                  state_q    <= StDesc;
                  b_q        <= '0;
                  desc_ready <= 1'b1;
               end else begin
                  state_q   <= StWin;
                  win_ready <= 1'b1;
               end
            end
            default: state_q <= StDesc;
         endcase
         // Placed last so a clear coincident with commit overrides the best update.
         if (frame_clear) begin
            best_valid <= 1'b0;
            best_score <= '0;
            best_idx   <= '0;
            win_idx_q  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ncc_match_engine.sv
// Directed-plus-random bench for ncc_match_engine; scores checked against a plain
// sum-of-products model over template and window arrays.
module tb_ncc_match_engine;

   localparam int PIX_W   = 8;
   localparam int TPL_DIM = 16;
   localparam int LANES   = 4;
   localparam int ACC_W   = 32;
   localparam int IDX_W   = 16;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic                     desc_valid;
   logic                     desc_ready;
   logic [LANES*PIX_W-1:0]   desc_data;
   logic                     desc_reload;
   logic                     win_valid;
   logic                     win_ready;
   logic [TPL_DIM*PIX_W-1:0] win_data;
   logic                     frame_clear;
   logic                     score_valid;
   logic [ACC_W-1:0]         score;
   logic                     best_valid;
   logic [ACC_W-1:0]         best_score;
   logic [IDX_W-1:0]         best_idx;

   ncc_match_engine #(
      .PIX_W  (PIX_W),
      .TPL_DIM(TPL_DIM),
      .LANES  (LANES),
      .ACC_W  (ACC_W),
      .IDX_W  (IDX_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_data  (desc_data),
      .desc_reload(desc_reload),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .frame_clear(frame_clear),
      .score_valid(score_valid),
      .score      (score),
      .best_valid (best_valid),
      .best_score (best_score),
      .best_idx   (best_idx)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0]  tpl_m [TPL_DIM][TPL_DIM];
   logic [7:0]  win_m [TPL_DIM][TPL_DIM];
   logic        bv_m;
   logic [31:0] bs_m;
   logic [15:0] bi_m;
   logic [15:0] idx_m;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      bv_m  = 1'b0;
      bs_m  = '0;
      bi_m  = '0;
      idx_m = '0;
   endtask

   function automatic logic [31:0] model_score();
      int unsigned s = 0;
      for (int r = 0; r < TPL_DIM; r++)
         for (int c = 0; c < TPL_DIM; c++)
            s += int'(tpl_m[r][c]) * int'(win_m[r][c]);
      return s;
   endfunction

   function automatic logic [TPL_DIM*PIX_W-1:0] pack_row(input int r);
      logic [TPL_DIM*PIX_W-1:0] v;
      for (int c = 0; c < TPL_DIM; c++) v[(TPL_DIM - 1 - c) * PIX_W +: PIX_W] = win_m[r][c];
      return v;
   endfunction

   // mode 0: every pixel = k; mode 1: random pixels
   task automatic fill_tpl(input int mode, input logic [7:0] k);
      for (int r = 0; r < TPL_DIM; r++)
         for (int c = 0; c < TPL_DIM; c++) tpl_m[r][c] = (mode == 0) ? k : 8'($urandom);
   endtask

   task automatic fill_win(input int mode, input logic [7:0] k);
      for (int r = 0; r < TPL_DIM; r++)
         for (int c = 0; c < TPL_DIM; c++) win_m[r][c] = (mode == 0) ? k : 8'($urandom);
   endtask

   task automatic load_tpl(input bit gaps);
      for (int k = 0; k < TPL_DIM * TPL_DIM / LANES; k++) begin
         int row;
         int cb;
         row = k / (TPL_DIM / LANES);
         cb  = (k % (TPL_DIM / LANES)) * LANES;
         if (gaps && $urandom_range(0, 1) == 1) begin
            desc_valid = 1'b0;
            @(posedge clk); #1;
            chk("desc_ready_gap", desc_ready, 1);
         end
         desc_valid = 1'b1;
         desc_data  = {tpl_m[row][cb], tpl_m[row][cb+1], tpl_m[row][cb+2], tpl_m[row][cb+3]};
         chk("desc_ready_load", desc_ready, 1);
         chk("win_ready_in_desc", win_ready, 0);
         @(posedge clk); #1;
      end
      desc_valid = 1'b0;
      chk("desc_ready_after_load", desc_ready, 0);
      chk("win_ready_after_load", win_ready, 1);
   endtask

   task automatic send_window(input bit gaps, input int reload_row, input bit clear_commit);
      logic [31:0] exp;
      exp = model_score();
      for (int r = 0; r < TPL_DIM; r++) begin
         if (gaps) begin
            win_valid = 1'b0;
            @(posedge clk); #1;
         end
         chk("win_ready_row", win_ready, 1);
         win_valid   = 1'b1;
         win_data    = pack_row(r);
         desc_reload = (r == reload_row);
         @(posedge clk); #1;
      end
      win_valid   = 1'b0;
      desc_reload = 1'b0;
      chk("score_valid_commit", score_valid, 1);
      chk("score", score, exp);
      chk("win_ready_commit", win_ready, 0);
      chk("desc_ready_commit", desc_ready, 0);
      if (clear_commit) begin
         frame_clear = 1'b1;
         model_clear();
      end else begin
         if (!bv_m || exp > bs_m) begin
            bv_m = 1'b1;
            bs_m = exp;
            bi_m = idx_m;
         end
         idx_m++;
      end
      @(posedge clk); #1;
      frame_clear = 1'b0;
      chk("score_valid_pulse_end", score_valid, 0);
      chk("score_hold", score, exp);
      chk("best_valid", best_valid, bv_m);
      chk("best_score", best_score, bs_m);
      chk("best_idx", best_idx, bi_m);
      chk("desc_ready_after_commit", desc_ready, (reload_row >= 0) ? 1 : 0);
      chk("win_ready_after_commit", win_ready, (reload_row >= 0) ? 0 : 1);
   endtask

   task automatic reload_now(input bit clr);
      desc_reload = 1'b1;
      frame_clear = clr;
      @(posedge clk); #1;
      desc_reload = 1'b0;
      frame_clear = 1'b0;
      if (clr) model_clear();
      chk("desc_ready_reload", desc_ready, 1);
      chk("best_valid_reload", best_valid, bv_m);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_desc_ready"}, desc_ready, 1);
      chk({tag, "_win_ready"}, win_ready, 0);
      chk({tag, "_score_valid"}, score_valid, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_best_valid"}, best_valid, 0);
      chk({tag, "_best_score"}, best_score, 0);
      chk({tag, "_best_idx"}, best_idx, 0);
   endtask

   initial begin
      desc_valid  = 1'b0;
      desc_data   = '0;
      desc_reload = 1'b0;
      win_valid   = 1'b0;
      win_data    = '0;
      frame_clear = 1'b0;
      model_clear();
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Template of 2s, window of 1s
      fill_tpl(0, 8'd2);
      load_tpl(1'b0);
      fill_win(0, 8'd1);
      send_window(1'b0, -1, 1'b0);

      // Full-scale: no overflow, then an all-zero window keeps the best
      reload_now(1'b1);
      fill_tpl(0, 8'd255);
      load_tpl(1'b0);
      fill_win(0, 8'd255);
      send_window(1'b0, -1, 1'b0);
      fill_win(0, 8'd0);
      send_window(1'b0, -1, 1'b0);

      // Sparse windows 100, 300, 300: tie keeps the earlier index
      reload_now(1'b1);
      fill_tpl(0, 8'd1);
      load_tpl(1'b0);
      fill_win(0, 8'd0);
      win_m[0][0] = 8'd100;
      send_window(1'b0, -1, 1'b0);
      fill_win(0, 8'd0);
      win_m[3][4] = 8'd150;
      win_m[9][2] = 8'd150;
      send_window(1'b0, -1, 1'b0);
      fill_win(0, 8'd0);
      win_m[15][15] = 8'd200;
      win_m[0][7]   = 8'd100;
      send_window(1'b0, -1, 1'b0);

      // Random template with desc gaps; same window at full rate and with gaps
      reload_now(1'b0);
      fill_tpl(1, 8'd0);
      load_tpl(1'b1);
      fill_win(1, 8'd0);
      send_window(1'b0, -1, 1'b0);
      send_window(1'b1, -1, 1'b0);
      fill_win(1, 8'd0);
      send_window(1'b1, -1, 1'b0);

      // Reload requested mid-window: window commits, then a new template is used
      fill_win(1, 8'd0);
      send_window(1'b0, 5, 1'b0);
      fill_tpl(1, 8'd0);
      load_tpl(1'b0);
      for (int i = 0; i < 3; i++) begin
         fill_win(1, 8'd0);
         send_window(1'b0, -1, 1'b0);
      end

      // frame_clear coincident with commit, then index restarts at 0
      fill_win(1, 8'd0);
      send_window(1'b0, -1, 1'b1);
      fill_win(1, 8'd0);
      send_window(1'b0, -1, 1'b0);

      // Asynchronous reset mid-window at row 7
      fill_win(1, 8'd0);
      for (int r = 0; r < 7; r++) begin
         win_valid = 1'b1;
         win_data  = pack_row(r);
         @(posedge clk); #1;
      end
      win_valid = 1'b0;
      rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      fill_tpl(1, 8'd0);
      load_tpl(1'b0);
      fill_win(1, 8'd0);
      send_window(1'b0, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ncc_match_engine.md
Name: ncc_match_engine

Overview:
- Parametrised successor to the vision-pipeline NCC correlator.
- Holds a TPL_DIM x TPL_DIM descriptor (template) loaded through a valid/ready stream. It scores a stream of candidate windows, arriving one row per beat, by unsigned cross-correlation (sum of pixel products).
- Tracks the best score and its window index since the last frame_clear.
- Sits between the descriptor/window fetch logic and the match-result consumer.

Parameters:
- PIX_W, 8, pixel width (unsigned).
- TPL_DIM, 16, template/window edge length in pixels.
- LANES, 4, pixels per descriptor beat; TPL_DIM must be a multiple of LANES.
- ACC_W, 32, score width; must be >= 2*PIX_W + clog2(TPL_DIM*TPL_DIM). This is an elaboration-time check.
- IDX_W, 16, window index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor beat valid.
- desc_ready  out  1  engine accepts descriptor beat.
- desc_data  in  LANES*PIX_W  descriptor pixels; lane 0 in MSBs, row-major order.
- desc_reload  in  1  pulse; return to descriptor loading.
- win_valid  in  1  window row beat valid.
- win_ready  out  1  engine accepts window row.
- win_data  in  TPL_DIM*PIX_W  one window row; column 0 in MSBs.
- frame_clear  in  1  pulse; clear best tracking and window index.
- score_valid  out  1  one-cycle pulse, score holds a finished window score.
- score  out  ACC_W  score of the window just completed.
- best_valid  out  1  at least one window scored since clear.
- best_score  out  ACC_W  greatest score since clear.
- best_idx  out  IDX_W  index of the window that produced best_score.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to S_DESC; all counters and the accumulator are 0.
  - Outputs: desc_ready=1, win_ready=0, score_valid=0, score=0, best_valid=0, best_score=0, best_idx=0.
  - Template memory contents are don't-care.
- S_DESC:
  - desc_ready=1, win_ready=0.
  - Each desc_valid&desc_ready beat writes LANES pixels at beat counter position b, then b increments.
  - Total beats = TPL_DIM*TPL_DIM/LANES (64 with defaults).
  - On the last beat: b wraps to 0 and the next state is S_WIN.
  - desc_valid low stalls with no change.
- S_WIN:
  - win_ready=1, desc_ready=0.
  - On each win_valid&win_ready beat at row counter r: acc <= (r==0 ? 0 : acc) + sum over c of win[c]*tpl[r][c]. Products are full 2*PIX_W unsigned; the sum is zero-extended to ACC_W.
  - r increments per beat. On r==TPL_DIM-1 the beat wraps r to 0 and the next state is S_COMMIT.
  - win_valid gaps stall with no change.
- S_COMMIT (exactly one cycle):
  - win_ready=0, desc_ready=0.
  - score_valid=1, score=acc. Latency: score_valid is asserted the cycle after the last row beat.
  - If !best_valid or acc > best_score (strict; the earliest window wins ties): best_score<=acc, best_idx<=win_idx, best_valid<=1.
  - win_idx increments (wraps modulo 2^IDX_W).
  - Next state: S_DESC if a desc_reload is pending, else S_WIN.
  - Throughput: TPL_DIM+1 cycles per window at full rate.
- desc_reload:
  - In S_WIN with r==0: next state is S_DESC and b=0. Best tracking is kept.
  - In S_WIN with r!=0: the request is latched as pending and honoured after the window's S_COMMIT.
  - In S_COMMIT: latched as pending, honoured at the end of that cycle.
  - Ignored in S_DESC.
- frame_clear:
  - Any state, registered: best_valid<=0, best_score<=0, best_idx<=0, win_idx<=0.
  - Coincident with S_COMMIT: clear wins. score_valid still pulses with that score, but the score is not recorded as best. win_idx is 0 afterwards.
  - A frame_clear never aborts a partially accumulated window.
- score holds its value until the next S_COMMIT.

Test Plan:
- Defaults. Load a template of all 2s (64 beats of 32'h02020202), then one window of all 1s (16 row beats) -> score_valid one cycle after the 16th beat, score=512; best_score=512, best_idx=0, best_valid=1.
- Template all 255, window all 255 -> score=16,646,400 with no overflow. Then a window of all 0s -> score=0; best remains 16,646,400 at idx 0.
- Three windows scoring 100, 300, 300 (sparse patterns) -> best_score=300, best_idx=1 (tie keeps the earlier window).
- win_valid toggling every other cycle, and desc_valid gaps during load -> same scores as the full-rate run; win_ready low during S_DESC and S_COMMIT.
- desc_reload asserted at row 5 of a window -> that window commits normally, then desc_ready=1. A new template loads and the next window uses it; win_idx continues.
- rst_n low mid-window at row 7 -> all outputs return to reset values immediately, desc_ready=1. frame_clear coincident with commit -> score_valid=1, best_valid=0.
